led_status_ctrl: RTL
====================

# led_status_ctrl

Board-level status indicator that drives the four user LEDs from the CNN accelerator's control events. It sits downstream of the inference controller and replaces the free-running blinker: led[0] remains a prescaler heartbeat, and led[1..3] show busy, done and error status. It turns single-cycle control pulses into human-visible LED patterns using a shared prescaler tick, per-LED stretch counters and a small run-state machine.

## Interface
- PRESCALE_W, 24, width of the free-running prescaler; tick period = 2^PRESCALE_W cycles (min 2)
- STRETCH_TICKS, 4, ticks the done LED is held after a done event (1..255; 8-bit counter)
- clk  input  1  system clock; all logic on rising edge
- rst  input  1  synchronous, active-high reset
- start_i  input  1  one-cycle pulse: inference started
- done_i  input  1  one-cycle pulse: inference finished OK
- err_i  input  1  one-cycle pulse: inference aborted with error
- err_clr_i  input  1  one-cycle pulse: operator/host clears the error
- led  output  4  led[0] heartbeat, led[1] busy, led[2] done, led[3] error

## Operation
- Prescaler: PRESCALE_W-bit up-counter that wraps freely. tick = 1 in the cycle where prescaler == all-ones, i.e. the same cycle in which it wraps to 0. led[0] = prescaler MSB.
- State machine states: IDLE, BUSY, ERROR. Reset state: IDLE.
- IDLE: start_i -> BUSY; err_i -> ERROR; done_i ignored.
- BUSY: err_i -> ERROR; done_i -> IDLE and load the stretch counter with STRETCH_TICKS; start_i ignored.
- ERROR: err_clr_i -> IDLE; start_i and done_i ignored; a further err_i keeps the state ERROR and does not restart the blink.
- Priority when events coincide in one cycle: err_i > done_i > start_i. err_i together with err_clr_i leaves the block in ERROR.
- Stretch counter (8 bit):
  - Loaded on a BUSY->IDLE done transition; a new load overwrites any remaining count.
  - Otherwise decrements by 1 on each tick while non-zero.
  - Cleared on entry to ERROR.
- Blink register:
  - Set to 1 on entry to ERROR from IDLE or BUSY.
  - Toggles on each tick while in ERROR.
  - Forced to 0 outside ERROR.
- Outputs:
  - led[1] = (state == BUSY).
  - led[2] = (stretch != 0).
  - led[3] = blink.
  - All LED outputs are registered or taken directly from registered state; there are no combinational paths from inputs to outputs.

## Timing
- Reset: prescaler = 0, state = IDLE, stretch = 0, blink = 0, led = 4'b0000 in the cycle after rst is sampled high. rst has priority over every event. rst asserted mid-BUSY or mid-ERROR returns the block to IDLE with all LEDs off.
- Event latency: an input sampled high at edge N changes state and counters at edge N, so the LEDs reflect it from edge N onward (one cycle after the pulse is presented).
- Done stretch:
  - led[2] rises with the done transition.
  - It falls on the STRETCH_TICKS-th tick after that.
  - Lit duration is between (STRETCH_TICKS-1)*2^PRESCALE_W+1 and STRETCH_TICKS*2^PRESCALE_W cycles.
  - If the load and a tick occur in the same cycle, the load wins and no decrement happens that cycle.
- Error blink:
  - led[3] goes high at the error edge.
  - It toggles at every tick edge afterwards, giving a period of 2*2^PRESCALE_W.
  - It drops the cycle after err_clr_i is sampled.
- Heartbeat: led[0] has a 50% duty cycle and a period of 2^PRESCALE_W cycles. It is unaffected by events and runs from reset.
- Inputs are synchronous to clk. Multi-cycle-high inputs are treated as repeated pulses, which is harmless given the ignore rules.

## Test plan
- Reset, PRESCALE_W=4: hold rst 3 cycles -> led=0000. After release, led[0] rises at cycle 8 and falls at cycle 16; tick fires when prescaler=15.
- Normal run, PRESCALE_W=4, STRETCH_TICKS=2: start_i at cycle 20 -> led[1]=1 from cycle 21. done_i at cycle 40 -> led[1]=0 and led[2]=1 from cycle 41. led[2] falls after the 2nd tick (ticks at prescaler=15, i.e. cycles 47 and 63 -> led[2]=0 from cycle 64).
- Error path: start_i, then err_i -> led[1]=0, led[3]=1 next cycle, toggling every 16 cycles. done_i and start_i while in ERROR -> no change. err_clr_i -> led[3]=0 next cycle, state IDLE.
- Simultaneous events: in BUSY, done_i and err_i together -> ERROR, led[2] stays 0. In ERROR, err_i and err_clr_i together -> stays ERROR.
- Load/tick collision: done_i in the same cycle as tick -> stretch = STRETCH_TICKS (not decremented). A second done after a re-start mid-stretch reloads the counter.
- Reset mid-operation: rst during BUSY with stretch active, and again during ERROR -> led=0000 the next cycle, and subsequent start_i behaves as from IDLE.

Source files
------------

// File: rtl/led_status_ctrl_if.sv
// Control-event bundle into the LED status block, plus the LED outputs it drives.
interface led_status_ctrl_if;
  logic       start_i;
  logic       done_i;
  logic       err_i;
  logic       err_clr_i;
  logic [3:0] led;

  modport master (output start_i, output done_i, output err_i, output err_clr_i, input led);
  modport slave  (input start_i, input done_i, input err_i, input err_clr_i, output led);
endinterface

// File: rtl/led_status_ctrl.sv
// Turns one-cycle inference control pulses into visible LED patterns:
// heartbeat, busy, stretched done and blinking error.
module led_status_ctrl #(
  parameter int PRESCALE_W    = 24,
  parameter int STRETCH_TICKS = 4
) (
  input  logic              clk,
  input  logic              rst,
  led_status_ctrl_if.slave  bus
);

  typedef enum logic [1:0] {IDLE, BUSY, ERROR} state_t;

  localparam logic [PRESCALE_W-1:0] PRE_ONE   = {{(PRESCALE_W-1){1'b0}}, 1'b1};
  localparam logic [7:0]            STRETCH_LD = 8'(STRETCH_TICKS);

  state_t                state;
  logic [PRESCALE_W-1:0] prescaler;
  logic [7:0]            stretch;
  logic                  blink;
  logic                  tick;

  assign tick = &prescaler;

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= IDLE;
      prescaler <= '0;
      stretch   <= '0;
      blink     <= 1'b0;
    end else begin
      prescaler <= prescaler + PRE_ONE;
      // Default behaviour; the state-specific branches below override it.
      if (tick && stretch != 8'd0) stretch <= stretch - 8'd1;
      if (tick && state == ERROR)  blink   <= ~blink;

      case (state)
        IDLE: begin
          if (bus.err_i) begin
            state   <= ERROR;
            blink   <= 1'b1;
            stretch <= '0;
          end else if (bus.start_i) begin
            state <= BUSY;
          end
        end
        BUSY: begin
          if (bus.err_i) begin
            state   <= ERROR;
            blink   <= 1'b1;
            stretch <= '0;
          end else if (bus.done_i) begin
            state   <= IDLE;
            stretch <= STRETCH_LD;
          end
        end
        ERROR: begin
          // A repeated err_i keeps the blink phase; clear loses to err_i.
          if (bus.err_clr_i && !bus.err_i) begin
            state <= IDLE;
            blink <= 1'b0;
          end
        end
        default: begin
          state <= IDLE;
          blink <= 1'b0;
        end
      endcase
    end
  end

  assign bus.led = {blink, (stretch != 8'd0), (state == BUSY), prescaler[PRESCALE_W-1]};

endmodule
